// File: rtl/gcd_if.sv
// Host-side handshake between the GCD wrapper and the controller:
// start/operands in, busy/done/result/iteration count out.
interface gcd_if #(
  parameter int W   = 4,
  parameter int ITW = 8
);
  logic           start;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic [ITW-1:0] iter_count;

  modport master (
    output start, a_in, b_in,
    input  busy, done, result, iter_count
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, result, iter_count
  );
endinterface

// File: rtl/gcd_controller.sv
// Subtractive GCD sequencer driving an external 4-function ALU
// (00 a-b, 01 b-a, 10 a==b, 11 a>b) with a start/busy/done handshake.
module gcd_controller #(
  parameter int W   = 4,
  parameter int ITW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  gcd_if.slave         host,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_sel,
  output logic         alu_en,
  input  logic [W-1:0] alu_out
);

  typedef enum logic [2:0] {
    IDLE, ZCHK, CMP_EQ, CMP_GT, SUB_AB, SUB_BA, DONE
  } state_t;

  localparam logic [1:0] SEL_SUB_AB = 2'b00;
  localparam logic [1:0] SEL_SUB_BA = 2'b01;
  localparam logic [1:0] SEL_EQ     = 2'b10;
  localparam logic [1:0] SEL_GT     = 2'b11;

  state_t         state, nxt;
  logic [W-1:0]   ra, rb, result_q;
  logic [ITW-1:0] iter_q, iter_inc;
  logic           busy_q, done_q;
  logic [1:0]     nxt_sel;
  logic           nxt_en;

  // NOTE: every variable in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:           if (host.start) nxt = ZCHK;
      ZCHK:           nxt = (ra == '0 || rb == '0) ? DONE : CMP_EQ;
      CMP_EQ:         nxt = alu_out[0] ? DONE : CMP_GT;
      CMP_GT:         nxt = alu_out[0] ? SUB_AB : SUB_BA;
      SUB_AB, SUB_BA: nxt = CMP_EQ;
      DONE:           nxt = IDLE;
      default:        nxt = IDLE;
    endcase
  end

  // ALU controls are registered from the next state so they are valid
  // during the very cycle the FSM consumes alu_out.
  always_comb begin
    nxt_sel = SEL_SUB_AB;
    nxt_en  = 1'b0;
    unique case (nxt)
      CMP_EQ: begin nxt_sel = SEL_EQ;     nxt_en = 1'b1; end
      CMP_GT: begin nxt_sel = SEL_GT;     nxt_en = 1'b1; end
      SUB_AB: begin nxt_sel = SEL_SUB_AB; nxt_en = 1'b1; end
      SUB_BA: begin nxt_sel = SEL_SUB_BA; nxt_en = 1'b1; end
      default: ;
    endcase
  end

  assign iter_inc = (iter_q == '1) ? iter_q : iter_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ra       <= '0;
      rb       <= '0;
      result_q <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_en   <= 1'b0;
      alu_sel  <= SEL_SUB_AB;
    end else begin
      state   <= nxt;
      busy_q  <= (nxt != IDLE);
      done_q  <= (nxt == DONE);
      alu_en  <= nxt_en;
      alu_sel <= nxt_sel;
      unique case (state)
        IDLE: if (host.start) begin
          ra     <= host.a_in;
          rb     <= host.b_in;
          iter_q <= '0;
        end
        ZCHK: begin
          if (ra == '0)      result_q <= rb;
          else if (rb == '0) result_q <= ra;
        end
        CMP_EQ: if (alu_out[0]) result_q <= ra;
        SUB_AB: begin
          ra     <= alu_out;
          iter_q <= iter_inc;
        end
        SUB_BA: begin
          rb     <= alu_out;
          iter_q <= iter_inc;
        end
        default: ;
      endcase
    end
  end

  assign alu_a           = ra;
  assign alu_b           = rb;
  assign host.busy       = busy_q;
  assign host.done       = done_q;
  assign host.result     = result_q;
  assign host.iter_count = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: directed vector table, async-reset abort,
// exhaustive operand sweep and randomized runs against a Euclid model.
module tb_gcd_controller;

  localparam int W   = 4;
  localparam int ITW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   alu_a, alu_b, alu_out;
  logic [1:0]     alu_sel;
  logic           alu_en;

  gcd_if #(.W(W), .ITW(ITW)) bus ();

  gcd_controller #(.W(W), .ITW(ITW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_en  (alu_en),
    .alu_out (alu_out)
  );

  always #5 clk = ~clk;

  // Shared combinational ALU that the controller sequences.
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      2'b00: alu_out = alu_a - alu_b;
      2'b01: alu_out = alu_b - alu_a;
      2'b10: alu_out = W'(alu_a == alu_b);
      2'b11: alu_out = W'(alu_a > alu_b);
      default: alu_out = '0;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: Euclid by division. Subtraction steps = sum of quotients - 1.
  function automatic int ref_gcd(input int a, input int b);
    int x = a, y = b, t;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  function automatic int ref_steps(input int a, input int b);
    int x = a, y = b, t, s = 0;
    if (a == 0 || b == 0) return 0;
    while (y != 0) begin s += x / y; t = x % y; x = y; y = t; end
    return s - 1;
  endfunction

  function automatic int ref_lat(input int a, input int b);
    if (a == 0 || b == 0) return 2;
    return 3 + 3 * ref_steps(a, b);
  endfunction

  // Runs one GCD; cycle 0 is the cycle start is presented, lat is the
  // cycle in which done is seen (-1 if it never comes).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit pester,
                        output logic [W-1:0] res, output logic [ITW-1:0] it,
                        output int lat, output bit busy_ok, output bit pulse_ok,
                        output bit hold_ok, output int en_cnt, output logic [31:0] seq);
    logic [W-1:0] prev_res;
    int cyc;
    bit seen;
    prev_res = bus.result;
    busy_ok = 1; pulse_ok = 1; hold_ok = 1; en_cnt = 0; seq = '0;
    lat = -1; seen = 0; res = '0; it = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b;
    cyc = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (alu_en) begin en_cnt++; seq = {seq[29:0], alu_sel}; end
      if (!bus.busy) busy_ok = 0;
      if (bus.done) begin
        seen = 1; lat = cyc; res = bus.result; it = bus.iter_count;
      end else if (bus.result !== prev_res) hold_ok = 0;
      bus.start = (pester && !seen) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pester) begin
        bus.a_in = W'($urandom);
        bus.b_in = W'($urandom);
      end
    end
    @(negedge clk);
    if (bus.done || bus.busy) pulse_ok = 0;
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    bit           pester;
    logic [W-1:0] exp_res;
    int           exp_iter;
    int           exp_lat;
    int           exp_en;
    bit           chk_seq;
    logic [31:0]  exp_seq;
  } vec_t;

  vec_t tbl[6];

  logic [W-1:0]   res;
  logic [ITW-1:0] it;
  int             lat, en_cnt;
  bit             busy_ok, pulse_ok, hold_ok;
  logic [31:0]    seq;

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    int ga, gb;
    tbl[0] = '{4'd12, 4'd8,  1'b0, 4'd4,  2,  9,  7, 1'b1, 32'b10_11_00_10_11_01_10};
    tbl[1] = '{4'd15, 4'd15, 1'b0, 4'd15, 0,  3,  1, 1'b1, 32'b10};
    tbl[2] = '{4'd0,  4'd9,  1'b0, 4'd9,  0,  2,  0, 1'b0, 32'd0};
    tbl[3] = '{4'd7,  4'd0,  1'b0, 4'd7,  0,  2,  0, 1'b0, 32'd0};
    tbl[4] = '{4'd0,  4'd0,  1'b0, 4'd0,  0,  2,  0, 1'b0, 32'd0};
    tbl[5] = '{4'd15, 4'd1,  1'b1, 4'd1,  14, 45, 43, 1'b0, 32'd0};

    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(bus.busy), 0);
    check("reset_done",   32'(bus.done), 0);
    check("reset_result", 32'(bus.result), 0);
    check("reset_iter",   32'(bus.iter_count), 0);
    check("reset_alu_en", 32'(alu_en), 0);
    check("reset_alu_sel", 32'(alu_sel), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].pester, res, it, lat, busy_ok, pulse_ok, hold_ok, en_cnt, seq);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(tbl[i].exp_res));
      check($sformatf("vec%0d_iter", i),   32'(it), 32'(tbl[i].exp_iter));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d_alu_en_cycles", i), 32'(en_cnt), 32'(tbl[i].exp_en));
      check($sformatf("vec%0d_busy_while_run", i), 32'(busy_ok), 1);
      check($sformatf("vec%0d_done_one_cycle", i), 32'(pulse_ok), 1);
      check($sformatf("vec%0d_result_held", i), 32'(hold_ok), 1);
      if (tbl[i].chk_seq) check($sformatf("vec%0d_sel_seq", i), seq, tbl[i].exp_seq);
    end

    // Async reset mid-run (cycle 4 of a 9,6 run) aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 4'd9; bus.b_in = 4'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(bus.busy), 0);
    check("abort_done",   32'(bus.done), 0);
    check("abort_result", 32'(bus.result), 0);
    check("abort_alu_a",  32'(alu_a), 0);
    check("abort_alu_en", 32'(alu_en), 0);
    saw_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1;
    end
    check("abort_no_done", 32'(saw_done), 0);
    run_op(4'd9, 4'd6, 1'b0, res, it, lat, busy_ok, pulse_ok, hold_ok, en_cnt, seq);
    check("restart_result",  32'(res), 3);
    check("restart_latency", 32'(lat), 9);
    check("restart_iter",    32'(it), 2);

    // Exhaustive sweep against the Euclid model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), 1'b0, res, it, lat, busy_ok, pulse_ok, hold_ok, en_cnt, seq);
        check($sformatf("sweep_%0d_%0d_result", a, b),  32'(res), 32'(ref_gcd(a, b)));
        check($sformatf("sweep_%0d_%0d_iter", a, b),    32'(it), 32'(ref_steps(a, b)));
        check($sformatf("sweep_%0d_%0d_latency", a, b), 32'(lat), 32'(ref_lat(a, b)));
        check($sformatf("sweep_%0d_%0d_handshake", a, b), 32'(busy_ok && pulse_ok && hold_ok), 1);
      end
    end

    // Random operands with stray start pulses and operand changes mid-run.
    for (int n = 0; n < 40; n++) begin
      ga = $urandom_range(0, 15);
      gb = $urandom_range(0, 15);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(W'(ga), W'(gb), 1'b1, res, it, lat, busy_ok, pulse_ok, hold_ok, en_cnt, seq);
      check($sformatf("rand%0d_result", n),  32'(res), 32'(ref_gcd(ga, gb)));
      check($sformatf("rand%0d_iter", n),    32'(it), 32'(ref_steps(ga, gb)));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(ref_lat(ga, gb)));
      check($sformatf("rand%0d_handshake", n), 32'(busy_ok && pulse_ok && hold_ok), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Multi-cycle sequencer that computes GCD(a_in, b_in) by subtraction.
- Drives the shared 4-function combinational ALU: sel 00 = a-b, 01 = b-a, 10 = (a==b), 11 = (a>b).
- Owns the operand registers, the FSM and a start/busy/done handshake.
- Sits between the top-level GCD wrapper (user inputs and result display) and the ALU instance.

Parameters:
- W, 4, operand/result width; must match the ALU data width.
- ITW, 8, width of the iteration counter; the counter saturates at 2^ITW-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a_in  input  W  operand A, sampled on accepted start
- b_in  input  W  operand B, sampled on accepted start
- busy  output  1  high from the cycle after an accepted start until DONE is left
- done  output  1  one-cycle pulse when result is valid
- result  output  W  GCD value; held until the next accepted start
- iter_count  output  ITW  number of subtract steps in the last/current run
- alu_a  output  W  ALU operand a = register ra
- alu_b  output  W  ALU operand b = register rb
- alu_sel  output  2  ALU function select
- alu_en  output  1  ALU enable; high only in CMP_EQ, CMP_GT, SUB_AB, SUB_BA
- alu_out  input  W  ALU result; flags are read from bit 0 only

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; ra, rb, result, iter_count = 0.
  - busy = 0, done = 0, alu_en = 0, alu_sel = 00.
  - Reset asserted mid-run aborts the run; no done pulse is produced.
- All outputs are registered or decoded from state and registers only; there is no combinational path from start to any output.
- Outside SUB_AB/SUB_BA, ra and rb hold their values. alu_a/alu_b always follow ra/rb.
- IDLE:
  - busy = 0.
  - If start=1: ra <= a_in, rb <= b_in, iter_count <= 0, go to ZCHK.
- ZCHK, no ALU use:
  - If ra==0: result <= rb, go to DONE. This covers GCD(0,0) = 0.
  - Else if rb==0: result <= ra, go to DONE.
  - Else go to CMP_EQ.
- CMP_EQ, sel = 10:
  - If alu_out[0]=1: result <= ra, go to DONE.
  - Else go to CMP_GT.
- CMP_GT, sel = 11:
  - If alu_out[0]=1, go to SUB_AB.
  - Else go to SUB_BA. Equality was already excluded, so a<b.
- SUB_AB, sel = 00: ra <= alu_out; iter_count <= iter_count+1 (saturating); go to CMP_EQ.
- SUB_BA, sel = 01: rb <= alu_out; iter_count increments as in SUB_AB; go to CMP_EQ.
- DONE: done = 1 for exactly one cycle, busy = 1; go to IDLE.
- Latency: done asserts N cycles after the accepted-start edge.
  - N = 2 if either operand is 0.
  - Otherwise N = 3 + 3*iter.
  - Worst case for W=4 is GCD(15,1): 14 iterations, N = 45.
- Start while not in IDLE (including the DONE cycle) is ignored; no queuing.
- Operands change after start: they have no effect on the run in progress.
- Subtraction never underflows, because a step runs only after CMP_GT orders the operands.

Test Plan:
- Reset, then start with a=12, b=8 -> done 9 cycles after start; result = 4; iter_count = 2; alu_sel sequence 10, 11, 00, 10, 11, 01, 10.
- a=15, b=15 -> done at cycle 3; result = 15; iter_count = 0; exactly one alu_en cycle (sel = 10).
- a=0, b=9, then a=7, b=0, then a=0, b=0 -> done at cycle 2 each time; results 9, 7, 0; alu_en never asserted.
- a=15, b=1 -> done at cycle 45; result = 1; iter_count = 14. Pulse start=1 repeatedly while busy: no effect on the run, and result is unchanged until done.
- Start a=9, b=6; pull rst_n low at cycle 4 asynchronously (mid-cycle) -> outputs clear immediately with no done pulse. Restart with a=9, b=6 -> result = 3 at cycle 9.
- Exhaustive sweep of all 256 (a, b) pairs for W=4 -> result matches the reference GCD model; done is exactly one cycle wide; busy is low only in IDLE.
